// File: rtl/tlu_pkg.sv
// Shared types and constants for the TLU trigger transmitter.
package tlu_pkg;

    // TLU_TRIGGER protocol modes as presented on CONF_MODE.
    localparam logic [1:0] MODE_PULSE    = 2'd0;
    localparam logic [1:0] MODE_HS       = 2'd1;
    localparam logic [1:0] MODE_DATA     = 2'd2;
    localparam logic [1:0] MODE_RESERVED = 2'd3;

    // Transmitter state encoding.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StTrig    = 2'd1,
        StData    = 2'd2,
        StWaitLow = 2'd3
    } state_e;

    // The reserved mode behaves as a plain busy handshake.
    function automatic logic [1:0] mode_norm(input logic [1:0] mode);
        return (mode == MODE_RESERVED) ? MODE_HS : mode;
    endfunction

endpackage

// File: rtl/tlu_tx_hs_if.sv
// Trigger request side and TLU cable side of the transmitter.
interface tlu_tx_hs_if #(
    parameter int unsigned TRIG_ID_WIDTH = 15
) ();

    logic                     TRIG;
    logic [TRIG_ID_WIDTH-1:0] TRIG_ID;
    logic                     READY;
    logic                     BUSY_OUT;
    logic                     TLU_CLOCK;
    logic                     TLU_BUSY;
    logic                     TLU_TRIGGER;
    logic                     TLU_RESET;

    // Transmitter view: drives the TLU lines and reports its own status.
    modport master (
        input  TRIG,
        input  TRIG_ID,
        input  TLU_CLOCK,
        input  TLU_BUSY,
        output READY,
        output BUSY_OUT,
        output TLU_TRIGGER,
        output TLU_RESET
    );

    // Environment view: trigger generator plus the TLU itself.
    modport slave (
        output TRIG,
        output TRIG_ID,
        output TLU_CLOCK,
        output TLU_BUSY,
        input  READY,
        input  BUSY_OUT,
        input  TLU_TRIGGER,
        input  TLU_RESET
    );

endinterface

// File: rtl/tlu_sync.sv
// Multi-flop synchroniser for a single asynchronous input.
module tlu_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stages_q <= '0;
        end else begin
            stages_q <= {stages_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages_q[SYNC_STAGES-1];

endmodule

// File: rtl/tlu_tx_hs.sv
// TLU trigger transmitter: pulse, busy handshake and serial-ID handshake modes.
module tlu_tx_hs
    import tlu_pkg::*;
#(
    parameter int unsigned TRIG_ID_WIDTH = 15,
    parameter int unsigned TIMEOUT_WIDTH = 16,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                     SYS_CLK,
    input  logic                     SYS_RST_N,
    input  logic                     ENABLE,
    input  logic [1:0]               CONF_MODE,
    input  logic [7:0]               CONF_TRIG_LEN,
    input  logic [TIMEOUT_WIDTH-1:0] CONF_TIME_OUT,
    output logic [CNT_WIDTH-1:0]     SKIP_CNT,
    output logic [CNT_WIDTH-1:0]     TIMEOUT_CNT,
    input  logic                     CNT_CLR,
    tlu_tx_hs_if.master              bus
);

    logic busy_s;
    logic clk_s;
    logic clk_s_d;
    logic clk_rise;
    logic init_q;
    logic ready;
    logic accept;
    logic skip_evt;
    logic timeout_evt;
    logic busy_out;
    logic trig_d;
    logic trig_q;

    state_e                   state_d, state_q;
    logic [TRIG_ID_WIDTH:0]   sr_d, sr_q;
    logic [TIMEOUT_WIDTH-1:0] tmo_d, tmo_q;
    logic                     tmo_en_d, tmo_en_q;
    logic [7:0]               pulse_d, pulse_q;
    logic [1:0]               mode_d, mode_q;
    logic [CNT_WIDTH-1:0]     skip_cnt_d, skip_cnt_q;
    logic [CNT_WIDTH-1:0]     tmo_cnt_d, tmo_cnt_q;

    tlu_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_busy (
        .CLK  (SYS_CLK),
        .RST_N(SYS_RST_N),
        .d    (bus.TLU_BUSY),
        .q    (busy_s)
    );

    tlu_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_clk (
        .CLK  (SYS_CLK),
        .RST_N(SYS_RST_N),
        .d    (bus.TLU_CLOCK),
        .q    (clk_s)
    );

    // Edge detector on the synchronised TLU clock; init flag keeps READY low in reset.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            clk_s_d <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            clk_s_d <= clk_s;
            init_q  <= 1'b1;
        end
    end

    assign clk_rise = clk_s & ~clk_s_d;
    assign ready    = init_q & (state_q == StIdle) & ~busy_s & ENABLE;
    assign accept   = bus.TRIG & ready;
    assign skip_evt = bus.TRIG & ~ready & ENABLE;

    // Next-state logic; trig_d is the line level for the current state, registered below.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        tmo_d       = tmo_q;
        tmo_en_d    = tmo_en_q;
        pulse_d     = pulse_q;
        mode_d      = mode_q;
        timeout_evt = 1'b0;
        busy_out    = 1'b0;
        trig_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StTrig;
                    sr_d     = {bus.TRIG_ID, 1'b0};
                    tmo_d    = CONF_TIME_OUT;
                    tmo_en_d = |CONF_TIME_OUT;
                    pulse_d  = (CONF_TRIG_LEN == 8'd0) ? 8'd1 : CONF_TRIG_LEN;
                    mode_d   = mode_norm(CONF_MODE);
                end
            end
            StTrig: begin
                trig_d = 1'b1;
                if (mode_q == MODE_PULSE) begin
                    if (pulse_q <= 8'd1) begin
                        state_d = StIdle;
                    end else begin
                        pulse_d = pulse_q - 8'd1;
                    end
                end else begin
                    busy_out = 1'b1;
                    // Busy takes priority over a coincident timeout expiry.
                    if (busy_s) begin
                        state_d = (mode_q == MODE_DATA) ? StData : StWaitLow;
                    end else if (tmo_en_q && (tmo_q == TIMEOUT_WIDTH'(1))) begin
                        state_d     = StIdle;
                        timeout_evt = 1'b1;
                    end else if (tmo_q != '0) begin
                        tmo_d = tmo_q - TIMEOUT_WIDTH'(1);
                    end
                end
            end
            StData: begin
                busy_out = 1'b1;
                trig_d   = sr_q[0];
                if (!busy_s) begin
                    state_d = StIdle;
                end else if (clk_rise) begin
                    sr_d = sr_q >> 1;
                end
            end
            StWaitLow: begin
                busy_out = 1'b1;
                if (!busy_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Transaction state and the registered TLU_TRIGGER line.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_q  <= StIdle;
            sr_q     <= '0;
            tmo_q    <= '0;
            tmo_en_q <= 1'b0;
            pulse_q  <= 8'd0;
            mode_q   <= MODE_PULSE;
            trig_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            tmo_q    <= tmo_d;
            tmo_en_q <= tmo_en_d;
            pulse_q  <= pulse_d;
            mode_q   <= mode_d;
            trig_q   <= trig_d;
        end
    end

    // Saturating status counters; clear wins over a same-cycle increment.
    always_comb begin
        skip_cnt_d = skip_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        if (CNT_CLR) begin
            skip_cnt_d = '0;
            tmo_cnt_d  = '0;
        end else begin
            if (skip_evt && !(&skip_cnt_q)) begin
                skip_cnt_d = skip_cnt_q + CNT_WIDTH'(1);
            end
            if (timeout_evt && !(&tmo_cnt_q)) begin
                tmo_cnt_d = tmo_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Status counter registers.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            skip_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            skip_cnt_q <= skip_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign bus.READY       = ready;
    assign bus.BUSY_OUT    = busy_out;
    assign bus.TLU_TRIGGER = trig_q;
    assign bus.TLU_RESET   = 1'b0;
    assign SKIP_CNT        = skip_cnt_q;
    assign TIMEOUT_CNT     = tmo_cnt_q;

endmodule

// File: tb/tb_tlu_tx_hs.sv
// Scoreboard bench for tlu_tx_hs: pulse widths and serial ID bits are checked by monitors.
module tb_tlu_tx_hs;

    localparam int unsigned IdW  = 15;
    localparam int unsigned ToW  = 16;
    localparam int unsigned CntW = 4;

    logic            SYS_CLK = 1'b0;
    logic            SYS_RST_N = 1'b0;
    logic            ENABLE = 1'b1;
    logic [1:0]      CONF_MODE = 2'd0;
    logic [7:0]      CONF_TRIG_LEN = 8'd4;
    logic [ToW-1:0]  CONF_TIME_OUT = '0;
    logic            CNT_CLR = 1'b0;
    logic [CntW-1:0] SKIP_CNT;
    logic [CntW-1:0] TIMEOUT_CNT;

    tlu_tx_hs_if #(.TRIG_ID_WIDTH(IdW)) bus ();

    tlu_tx_hs #(
        .TRIG_ID_WIDTH(IdW),
        .TIMEOUT_WIDTH(ToW),
        .CNT_WIDTH    (CntW),
        .SYNC_STAGES  (2)
    ) dut (
        .SYS_CLK      (SYS_CLK),
        .SYS_RST_N    (SYS_RST_N),
        .ENABLE       (ENABLE),
        .CONF_MODE    (CONF_MODE),
        .CONF_TRIG_LEN(CONF_TRIG_LEN),
        .CONF_TIME_OUT(CONF_TIME_OUT),
        .SKIP_CNT     (SKIP_CNT),
        .TIMEOUT_CNT  (TIMEOUT_CNT),
        .CNT_CLR      (CNT_CLR),
        .bus          (bus.master)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_len_q[$];
    logic exp_bit_q[$];
    bit   pulse_mon_en = 1'b0;
    bit   bit_mon_en = 1'b0;
    int   hi_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge SYS_CLK);
            #1;
        end
    endtask

    task automatic fire(input logic [IdW-1:0] id);
        bus.TRIG_ID = id;
        bus.TRIG    = 1'b1;
        tick(1);
        bus.TRIG    = 1'b0;
    endtask

    // Count cycles until READY rises; a negative expectation only bounds the wait.
    task automatic wait_ready(input string name, input int exp_ticks, input int limit);
        int n = 0;
        while (bus.READY !== 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        if (bus.READY !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: READY not seen within %0d cycles", name, limit);
        end else if (exp_ticks >= 0) begin
            check(name, n, exp_ticks);
        end
    endtask

    task automatic wait_trig_low(input string name, input int exp_ticks, input int limit);
        int n = 0;
        while (bus.TLU_TRIGGER !== 1'b0 && n < limit) begin
            tick(1);
            n++;
        end
        if (bus.TLU_TRIGGER !== 1'b0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: TLU_TRIGGER still high after %0d cycles", name, limit);
        end else begin
            check(name, n, exp_ticks);
        end
    endtask

    // Pulse-width monitor: each completed high period pops one expected length.
    always @(negedge SYS_CLK) begin
        if (pulse_mon_en) begin
            if (bus.TLU_TRIGGER === 1'b1) begin
                hi_len++;
            end else if (hi_len != 0) begin
                if (exp_len_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pulse_len: unexpected pulse of %0d cycles", hi_len);
                end else begin
                    check("pulse_len", hi_len, exp_len_q.pop_front());
                end
                hi_len = 0;
            end
        end
    end

    // Serial ID monitor: the TLU samples the line on each rising TLU_CLOCK.
    always @(posedge bus.TLU_CLOCK) begin
        if (bit_mon_en) begin
            if (exp_bit_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL data_bit: unexpected clock edge, line %0b", bus.TLU_TRIGGER);
            end else begin
                check("data_bit", bus.TLU_TRIGGER, exp_bit_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IdW:0] pat;
        bus.TRIG      = 1'b0;
        bus.TRIG_ID   = '0;
        bus.TLU_CLOCK = 1'b0;
        bus.TLU_BUSY  = 1'b0;

        // Reset values.
        tick(3);
        check("rst_ready", bus.READY, 1'b0);
        check("rst_trigger", bus.TLU_TRIGGER, 1'b0);
        check("rst_busy_out", bus.BUSY_OUT, 1'b0);
        check("rst_skip", SKIP_CNT, 4'd0);
        check("rst_timeout", TIMEOUT_CNT, 4'd0);
        check("tlu_reset", bus.TLU_RESET, 1'b0);
        SYS_RST_N = 1'b1;
        tick(1);
        check("ready_after_rst", bus.READY, 1'b1);

        // Pulse mode: length 4, then length 0 which behaves as 1.
        pulse_mon_en = 1'b1;
        exp_len_q.push_back(4);
        fire(15'h0001);
        CONF_TRIG_LEN = 8'd9;  // latched at accept, must not stretch this pulse
        wait_ready("m0_ready_low", 4, 50);
        tick(3);
        check("m0_pulse_seen", exp_len_q.size(), 0);
        CONF_TRIG_LEN = 8'd0;
        exp_len_q.push_back(1);
        fire(15'h0002);
        tick(4);
        check("m0_len0_seen", exp_len_q.size(), 0);
        pulse_mon_en = 1'b0;
        wait_ready("m0_idle", -1, 20);

        // Busy handshake without timeout.
        CONF_MODE = 2'd1;
        fire(15'h0003);
        tick(9);
        check("m1_trig_high", bus.TLU_TRIGGER, 1'b1);
        check("m1_busy_out", bus.BUSY_OUT, 1'b1);
        bus.TLU_BUSY = 1'b1;
        wait_trig_low("m1_trig_drop", 4, 20);
        tick(46);
        check("m1_ready_in_busy", bus.READY, 1'b0);
        bus.TLU_BUSY = 1'b0;
        wait_ready("m1_ready_return", 3, 20);

        // Timeout of 20 cycles with TLU_BUSY never asserted.
        CONF_TIME_OUT = 16'd20;
        fire(15'h0004);
        CONF_TIME_OUT = 16'd5;  // latched at accept
        wait_ready("to_len", 20, 60);
        check("to_cnt", TIMEOUT_CNT, 4'd1);

        // Timeout disabled: waits indefinitely; triggers meanwhile are skipped.
        CONF_TIME_OUT = 16'd0;
        fire(15'h0005);
        tick(100);
        check("no_to_busy", bus.BUSY_OUT, 1'b1);
        check("no_to_cnt", TIMEOUT_CNT, 4'd1);
        for (int i = 0; i < 3; i++) begin
            bus.TRIG = 1'b1;
            tick(1);
            bus.TRIG = 1'b0;
            tick(2);
        end
        check("skip3", SKIP_CNT, 4'd3);
        bus.TLU_BUSY = 1'b1;
        tick(10);
        bus.TLU_BUSY = 1'b0;
        wait_ready("no_to_end", -1, 20);
        CNT_CLR = 1'b1;
        tick(1);
        CNT_CLR = 1'b0;
        check("clr_skip", SKIP_CNT, 4'd0);
        check("clr_timeout", TIMEOUT_CNT, 4'd0);

        // Saturation and clear priority during a stuck handshake.
        fire(15'h0006);
        bus.TRIG = 1'b1;
        tick(16);
        check("skip_sat", SKIP_CNT, 4'hF);
        CNT_CLR = 1'b1;
        tick(1);
        CNT_CLR = 1'b0;
        check("clr_priority", SKIP_CNT, 4'd0);
        tick(20);
        bus.TRIG = 1'b0;
        check("skip_sat2", SKIP_CNT, 4'hF);
        bus.TLU_BUSY = 1'b1;
        tick(10);
        bus.TLU_BUSY = 1'b0;
        wait_ready("sat_end", -1, 20);

        // ENABLE low: no accept, no skip count.
        ENABLE = 1'b0;
        tick(1);
        check("dis_ready", bus.READY, 1'b0);
        bus.TRIG = 1'b1;
        tick(1);
        bus.TRIG = 1'b0;
        tick(3);
        check("dis_skip", SKIP_CNT, 4'hF);
        check("dis_busy_out", bus.BUSY_OUT, 1'b0);
        ENABLE = 1'b1;
        tick(1);

        // Data handshake with serial ID 0x5A3C, then reset while still in DATA.
        CONF_MODE = 2'd2;
        fire(15'h5A3C);
        tick(10);
        bus.TLU_BUSY = 1'b1;
        tick(10);
        check("data_lead", bus.TLU_TRIGGER, 1'b0);
        pat = {15'h5A3C, 1'b0};
        for (int i = 0; i <= IdW; i++) begin
            exp_bit_q.push_back(pat[i]);
        end
        bit_mon_en = 1'b1;
        for (int i = 0; i <= IdW; i++) begin
            tick(10);
            bus.TLU_CLOCK = 1'b1;
            if (i < IdW) begin
                tick(10);
                bus.TLU_CLOCK = 1'b0;
            end
        end
        #2;
        bit_mon_en = 1'b0;
        check("data_bits_done", exp_bit_q.size(), 0);
        check("pre_rst_trigger", bus.TLU_TRIGGER, 1'b1);
        SYS_RST_N = 1'b0;
        #1;
        check("async_rst_trigger", bus.TLU_TRIGGER, 1'b0);
        check("async_rst_busy_out", bus.BUSY_OUT, 1'b0);
        check("async_rst_skip", SKIP_CNT, 4'd0);
        bus.TLU_BUSY  = 1'b0;
        bus.TLU_CLOCK = 1'b0;
        tick(2);
        SYS_RST_N = 1'b1;
        tick(4);
        check("post_rst_ready", bus.READY, 1'b1);
        check("post_rst_timeout", TIMEOUT_CNT, 4'd0);
        check("post_rst_trigger", bus.TLU_TRIGGER, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
